// File: rtl/shift_arbiter_ctrl_if.sv
// rtl/shift_arbiter_ctrl_if.sv - requester-facing bus of the shared shift sequencer
// Requesters drive the master side; the sequencer owns the slave side.
interface shift_arbiter_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic [1:0]       req;
  logic [WIDTH-1:0] data0;
  logic [AMT_W-1:0] amt0;
  logic             arith0;
  logic [WIDTH-1:0] data1;
  logic [AMT_W-1:0] amt1;
  logic             arith1;
  logic [1:0]       grant;
  logic [1:0]       ack;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] shift_q;

  modport master (
    output req, data0, amt0, arith0, data1, amt1, arith1,
    input  grant, ack, busy, result, shift_q
  );

  modport slave (
    input  req, data0, amt0, arith0, data1, amt1, arith1,
    output grant, ack, busy, result, shift_q
  );
endinterface

// File: rtl/shift_arbiter_ctrl.sv
// rtl/shift_arbiter_ctrl.sv - round-robin shared right-shift sequencer
// Loads the winner's operand, shifts one bit per clock, then acks for one cycle.
module shift_arbiter_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic                  clock_i,
  input  logic                  rst_i,
  shift_arbiter_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] AMT_ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             winner;
  logic [WIDTH-1:0] win_data;
  logic [AMT_W-1:0] win_amt;
  logic             win_arith;

  // Contention goes to whoever was not served last; a lone request always wins.
  always_comb begin
    if (bus.req == 2'b11) begin
      winner = ~last_grant_q;
    end else begin
      winner = bus.req[1];
    end
    win_data  = winner ? bus.data1  : bus.data0;
    win_amt   = winner ? bus.amt1   : bus.amt0;
    win_arith = winner ? bus.arith1 : bus.arith0;
  end

  always_comb begin
    state_d      = state_q;
    shift_reg_d  = shift_reg_q;
    count_d      = count_q;
    mode_d       = mode_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          shift_reg_d  = win_data;
          count_d      = win_amt;
          mode_d       = win_arith;
          grant_d      = winner ? 2'b10 : 2'b01;
          last_grant_d = winner;
          state_d      = (win_amt != AMT_ZERO) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_reg_d = {mode_q & shift_reg_q[WIDTH-1], shift_reg_q[WIDTH-1:1]};
        count_d     = count_q - AMT_ONE;
        if (count_q == AMT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d = shift_reg_q;
        grant_d  = 2'b00;
        state_d  = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      shift_reg_q  <= '0;
      count_q      <= '0;
      mode_q       <= 1'b0;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      shift_reg_q  <= shift_reg_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

  // During DONE the fresh result is forwarded so it is valid alongside ack.
  assign bus.grant   = grant_q;
  assign bus.ack     = (state_q == DONE) ? grant_q : 2'b00;
  assign bus.busy    = (state_q != IDLE);
  assign bus.result  = (state_q == DONE) ? shift_reg_q : result_q;
  assign bus.shift_q = shift_reg_q;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// tb/tb_shift_arbiter_ctrl.sv - directed self-checking bench for shift_arbiter_ctrl
module tb_shift_arbiter_ctrl;

  logic clock;
  logic rst;
  int   tests;
  int   fails;

  shift_arbiter_ctrl_if #(.WIDTH(8), .AMT_W(3)) sif ();

  shift_arbiter_ctrl #(.WIDTH(8), .AMT_W(3)) dut (
    .clock_i (clock),
    .rst_i   (rst),
    .bus     (sif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic apply_reset();
    @(negedge clock);
    rst = 1'b1;
    sif.req = 2'b00;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++; if (sif.grant !== 2'b00) begin fails++; $display("FAIL reset_grant got %b want 00", sif.grant); end
    tests++; if (sif.ack !== 2'b00) begin fails++; $display("FAIL reset_ack got %b want 00", sif.ack); end
    tests++; if (sif.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", sif.busy); end
    tests++; if (sif.result !== 8'h00) begin fails++; $display("FAIL reset_result got %h want 00", sif.result); end
    tests++; if (sif.shift_q !== 8'h00) begin fails++; $display("FAIL reset_shift_q got %h want 00", sif.shift_q); end
  endtask

  task automatic test_single_op(input string name, input bit who, input logic [7:0] d,
                                input logic [2:0] a, input bit ar, input logic [7:0] exp);
    logic [1:0] oh;
    int cyc;
    int gbad;
    oh = who ? 2'b10 : 2'b01;
    @(negedge clock);
    if (who) begin
      sif.data1 = d; sif.amt1 = a; sif.arith1 = ar;
    end else begin
      sif.data0 = d; sif.amt0 = a; sif.arith0 = ar;
    end
    sif.req = oh;
    @(negedge clock);
    cyc = 1;
    gbad = 0;
    while (sif.ack === 2'b00 && cyc < 20) begin
      if (sif.grant !== oh || sif.busy !== 1'b1) gbad++;
      @(negedge clock);
      cyc++;
    end
    tests++; if (sif.ack !== oh) begin fails++; $display("FAIL %s_ack got %b want %b", name, sif.ack, oh); end
    tests++; if (cyc != int'(a) + 1) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, cyc, int'(a) + 1); end
    tests++; if (sif.result !== exp) begin fails++; $display("FAIL %s_result got %h want %h", name, sif.result, exp); end
    tests++; if (gbad != 0 || sif.grant !== oh) begin fails++; $display("FAIL %s_grant_held got %0d bad cycles grant %b want 0 bad grant %b", name, gbad, sif.grant, oh); end
    sif.req = 2'b00;
    @(negedge clock);
    tests++; if (sif.busy !== 1'b0 || sif.grant !== 2'b00 || sif.ack !== 2'b00) begin
      fails++; $display("FAIL %s_idle got busy %b grant %b ack %b want 0 00 00", name, sif.busy, sif.grant, sif.ack);
    end
    tests++; if (sif.result !== exp) begin fails++; $display("FAIL %s_result_hold got %h want %h", name, sif.result, exp); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    logic [7:0] res [4];
    logic [1:0] exp_seq [4];
    logic [7:0] exp_res [4];
    int n;
    int cyc;
    int inv;
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_res = '{8'hC0, 8'h21, 8'hC0, 8'h21};
    apply_reset();
    sif.data0 = 8'h81; sif.amt0 = 3'd1; sif.arith0 = 1'b1;
    sif.data1 = 8'h42; sif.amt1 = 3'd1; sif.arith1 = 1'b0;
    sif.req = 2'b11;
    n = 0; cyc = 0; inv = 0;
    while (n < 4 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if ($countones(sif.grant) > 1 || $countones(sif.ack) > 1 || sif.busy !== (sif.grant != 2'b00)) inv++;
      if (sif.ack !== 2'b00) begin
        seq[n] = sif.ack;
        res[n] = sif.result;
        n++;
      end
    end
    sif.req = 2'b00;
    @(negedge clock);
    tests++; if (n != 4) begin fails++; $display("FAIL rr_ack_count got %0d want 4", n); end
    for (int i = 0; i < n; i++) begin
      tests++; if (seq[i] !== exp_seq[i]) begin fails++; $display("FAIL rr_grant_%0d got %b want %b", i, seq[i], exp_seq[i]); end
      tests++; if (res[i] !== exp_res[i]) begin fails++; $display("FAIL rr_result_%0d got %h want %h", i, res[i], exp_res[i]); end
    end
    tests++; if (inv != 0) begin fails++; $display("FAIL rr_invariants got %0d bad cycles want 0", inv); end
  endtask

  task automatic test_mid_request();
    int cyc;
    apply_reset();
    sif.data0 = 8'hF0; sif.amt0 = 3'd4; sif.arith0 = 1'b0;
    sif.req = 2'b01;
    @(negedge clock);
    @(negedge clock);
    sif.data1 = 8'h33; sif.amt1 = 3'd1; sif.arith1 = 1'b0;
    sif.req = 2'b11;
    cyc = 0;
    while (sif.ack === 2'b00 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    tests++; if (sif.ack !== 2'b01 || sif.result !== 8'h0F) begin
      fails++; $display("FAIL mid_first_ack got ack %b result %h want 01 0f", sif.ack, sif.result);
    end
    sif.req = 2'b10;
    @(negedge clock);
    tests++; if (sif.grant !== 2'b00 || sif.busy !== 1'b0) begin
      fails++; $display("FAIL mid_idle_gap got grant %b busy %b want 00 0", sif.grant, sif.busy);
    end
    @(negedge clock);
    tests++; if (sif.grant !== 2'b10 || sif.shift_q !== 8'h33) begin
      fails++; $display("FAIL mid_second_grant got grant %b shift_q %h want 10 33", sif.grant, sif.shift_q);
    end
    sif.data1 = 8'hFF;
    sif.amt1 = 3'd7;
    @(negedge clock);
    tests++; if (sif.ack !== 2'b10 || sif.result !== 8'h19) begin
      fails++; $display("FAIL mid_second_ack got ack %b result %h want 10 19", sif.ack, sif.result);
    end
    sif.req = 2'b00;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_shift();
    int acks;
    apply_reset();
    sif.data0 = 8'hFF; sif.amt0 = 3'd7; sif.arith0 = 1'b0;
    sif.req = 2'b01;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    tests++; if (sif.busy !== 1'b1 || sif.grant !== 2'b01) begin
      fails++; $display("FAIL rstmid_pre got busy %b grant %b want 1 01", sif.busy, sif.grant);
    end
    rst = 1'b1;
    sif.req = 2'b00;
    @(negedge clock);
    tests++; if (sif.grant !== 2'b00 || sif.ack !== 2'b00 || sif.busy !== 1'b0 || sif.result !== 8'h00) begin
      fails++; $display("FAIL rstmid_abort got grant %b ack %b busy %b result %h want 00 00 0 00",
                        sif.grant, sif.ack, sif.busy, sif.result);
    end
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (sif.ack !== 2'b00) acks++;
    end
    tests++; if (acks != 0) begin fails++; $display("FAIL rstmid_no_ack got %0d acks want 0", acks); end
    sif.amt0 = 3'd0; sif.data0 = 8'h11;
    sif.amt1 = 3'd0; sif.data1 = 8'h22;
    sif.req = 2'b11;
    @(negedge clock);
    tests++; if (sif.grant !== 2'b01) begin fails++; $display("FAIL rstmid_first_winner got %b want 01", sif.grant); end
    sif.req = 2'b00;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    sif.req = 2'b00;
    sif.data0 = '0; sif.amt0 = '0; sif.arith0 = 1'b0;
    sif.data1 = '0; sif.amt1 = '0; sif.arith1 = 1'b0;
    test_reset();
    test_single_op("log_b4", 1'b0, 8'hB4, 3'd3, 1'b0, 8'h16);
    test_single_op("ari_90", 1'b1, 8'h90, 3'd2, 1'b1, 8'hE4);
    test_single_op("log_90", 1'b1, 8'h90, 3'd2, 1'b0, 8'h24);
    test_single_op("amt0_5a", 1'b0, 8'h5A, 3'd0, 1'b0, 8'h5A);
    test_single_op("log7_80", 1'b0, 8'h80, 3'd7, 1'b0, 8'h01);
    test_single_op("ari7_80", 1'b1, 8'h80, 3'd7, 1'b1, 8'hFF);
    test_round_robin();
    test_mid_request();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_arbiter_ctrl.md
Name: shift_arbiter_ctrl

Overview:
- Sequencing controller for a right-shift datapath, shared between two requesters.
- Round-robin arbitration picks one request at a time.
- The granted operand is loaded into an internal shift register and shifted right by the requested amount, one bit per clock.
- The result is returned with a one-cycle acknowledge to the winner. Sits between client blocks and the shift datapath in the lab top level.

Parameters:
- WIDTH, 8, data/operand width in bits.
- AMT_W, 3, shift-amount width; maximum shift is 2^AMT_W-1.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  request per requester; held high until matching ack.
- data0  in  WIDTH  requester 0 operand.
- amt0  in  AMT_W  requester 0 shift amount.
- arith0  in  1  requester 0 mode: 0 = logical (zero fill), 1 = arithmetic (MSB fill).
- data1  in  WIDTH  requester 1 operand.
- amt1  in  AMT_W  requester 1 shift amount.
- arith1  in  1  requester 1 mode.
- grant  out  2  one-hot owner of the datapath; 00 when idle.
- ack  out  2  one-hot, one-cycle pulse; result valid in this cycle.
- busy  out  1  high whenever state != IDLE.
- result  out  WIDTH  last completed result; holds until overwritten.
- shift_q  out  WIDTH  live shift-register contents, for debug/observe.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high: rst sampled on posedge clock.
  - Reset drives state=IDLE, grant=00, ack=00, busy=0, result=0, shift_q=0, count=0, last_grant=1 (so requester 0 wins the first contention).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - No req: stay IDLE.
  - One req bit set: that requester wins.
  - Both set: winner is the requester not equal to last_grant.
  - On the edge the winner is picked:
    - shift_q <= winner data, count <= winner amt, mode <= winner arith.
    - grant <= one-hot(winner), last_grant <= winner.
    - Next state is SHIFT if amt != 0, else DONE.
- SHIFT:
  - Each edge: shift_q <= {fill, shift_q[WIDTH-1:1]}, where fill = mode ? shift_q[WIDTH-1] : 0. Then count <= count-1.
  - When count==1 at the edge, the final shift occurs and next state is DONE.
- DONE (exactly one cycle):
  - ack = grant, combinational from state, high this cycle only.
  - result <= shift_q on the exit edge; result is also driven from shift_q during DONE, so it is valid while ack is high.
  - Next state IDLE, grant <= 00.
- Latency: amt=k with a request pending in IDLE at edge E0 gives k shift edges E1..Ek; ack is high in the cycle after Ek. amt=0 gives ack in the cycle after E0. Total k+1 cycles from the grant edge to ack.
- Handshake:
  - A requester must hold req, data, amt and arith stable until the grant edge; operands are latched at that edge, so later changes are ignored.
  - A requester deasserts req on the edge ending its ack cycle.
  - A req still high in the IDLE cycle after ack is a new request; round-robin still applies, so the other requester wins if it is pending.
- No preemption: requests arriving while busy wait; they are evaluated only in IDLE.
- Reset mid-operation (any state) aborts: no ack issued, result cleared to 0, last_grant returns to 1.
- Shift amounts up to WIDTH-1 only. Logical shift by 7 of 8'h80 gives 8'h01. Arithmetic shift of a negative value saturates to all ones.
- ack and grant are never both-hot. busy == (grant != 00) at all times.

Test Plan:
- Reset then req=01, data0=8'hB4, amt0=3, arith0=0 -> grant=01 for 4 cycles; ack=01 in 4th cycle after grant edge; result=8'h16; busy low next cycle.
- req=10, data1=8'h90, amt1=2, arith1=1 -> ack=10 after 3 cycles; result=8'hE4. Same with arith1=0 -> 8'h24.
- amt0=0, data0=8'h5A -> DONE directly; ack=01 one cycle after grant edge; result=8'h5A.
- Both req high continuously from reset:
  - Grants alternate 01, 10, 01, 10.
  - First grant is requester 0.
  - No back-to-back grants to one requester while the other is pending.
- Request 1 asserted mid-shift of requester 0 -> requester 1 waits; granted the cycle after requester 0's ack returns to IDLE; operand 1 unaffected by the in-flight shift.
- rst pulsed during SHIFT of data0=8'hFF, amt0=7 -> next cycle: grant=00, ack=00, busy=0, result=0, no ack ever issued; subsequent contention grants requester 0 first.
